obstacle_spawner: RTL and testbench

- Consumer end of the 5-bit LFSR random source in the dinosaur game.
- Draws random values to set the inter-obstacle gap and the obstacle type.
- Holds up to 3 obstacle slots and scrolls them left each game tick at the current speed.
- Feeds the renderer and collision logic with per-slot valid, x and type.

---
 rtl/obstacle_spawner_if.sv | 45 ++++
 rtl/obstacle_spawner.sv | 144 ++++++++++++++
 tb/tb_obstacle_spawner.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/obstacle_spawner_if.sv
// obstacle_spawner_if
//   Bundles the game-side control inputs and the per-slot obstacle outputs
//   of the obstacle spawner.
//
//   Handshake: there is none. tick is a one-cycle enable, and rnd is
//   sampled only on the edge that needs it (game entry, spawn). Every
//   output is registered and valid in every cycle.
//
//   Signals
//     tick        game-tick enable pulse
//     run         game running (0 forces IDLE)
//     freeze      game over; hold everything
//     speed[2:0]  pixels per tick moved left
//     rnd[4:0]    LFSR value
//     obs_valid   per-slot active flag
//     obs_x       slot i x in [10i+9:10i]
//     obs_type    slot i type in [2i+1:2i]
//     spawn       pulse after a slot is loaded
//     dbg_state   FSM state (0 IDLE, 1 GAP, 2 FULL)
//     dbg_gap_cnt current gap counter
interface obstacle_spawner_if;
   logic        tick;
   logic        run;
   logic        freeze;
   logic [2:0]  speed;
   logic [4:0]  rnd;
   logic [2:0]  obs_valid;
   logic [29:0] obs_x;
   logic [5:0]  obs_type;
   logic        spawn;
   logic [1:0]  dbg_state;
   logic [5:0]  dbg_gap_cnt;

   // Game controller side.
   modport master (
      output tick, run, freeze, speed, rnd,
      input  obs_valid, obs_x, obs_type, spawn, dbg_state, dbg_gap_cnt
   );

   // Spawner side.
   modport slave (
      input  tick, run, freeze, speed, rnd,
      output obs_valid, obs_x, obs_type, spawn, dbg_state, dbg_gap_cnt
   );
endinterface

// File: rtl/obstacle_spawner.sv
// obstacle_spawner
//   Spawns obstacles into three slots at random intervals and scrolls them
//   left by `speed` pixels each game tick. Gap length is MIN_GAP + rnd
//   ticks of silence, then a spawn on the following tick. When all slots
//   are busy at spawn time the FSM parks in FULL and spawns on the first
//   tick that starts with a free slot.
//
//   Ports
//     clk    system clock
//     RESET  synchronous active-low reset
//     bus    obstacle_spawner_if.slave (controls in, slot state out)
module obstacle_spawner #(
   parameter logic [9:0] X_START = 10'd639,
   parameter int         MIN_GAP = 24
) (
   input  logic               clk,
   input  logic               RESET,
   obstacle_spawner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      FULL = 2'd2
   } state_t;

   localparam logic [5:0] MIN_GAP6 = 6'(MIN_GAP);

   state_t          state_q, state_d;
   logic [5:0]      gap_q, gap_d;
   logic [2:0]      valid_q, valid_d;
   logic [2:0][9:0] x_q, x_d;
   logic [2:0][1:0] type_q, type_d;
   logic            spawn_q, spawn_d;

   logic [5:0]      reload;
   logic [2:0]      free;
   logic            any_free;
   logic            do_spawn;
   logic            placed;

   // Free-slot decisions use the occupancy at the start of the tick, so a
   // slot that expires this tick is not reused until the next one.
   assign free     = ~valid_q;
   assign any_free = |free;
   assign reload   = MIN_GAP6 + {1'b0, bus.rnd};

   always_ff @(posedge clk) begin
      if (!RESET) begin
         state_q <= IDLE;
         gap_q   <= '0;
         valid_q <= '0;
         x_q     <= '0;
         type_q  <= '0;
         spawn_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         type_q  <= type_d;
         spawn_q <= spawn_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      gap_d    = gap_q;
      valid_d  = valid_q;
      x_d      = x_q;
      type_d   = type_q;
      spawn_d  = 1'b0;
      do_spawn = 1'b0;
      placed   = 1'b0;

      if (!bus.run) begin
         state_d = IDLE;
         gap_d   = '0;
         valid_d = '0;
         x_d     = '0;
         type_d  = '0;
      end else if (bus.freeze) begin
         // hold everything; spawn already defaults low
      end else begin
         case (state_q)
            IDLE: begin
               gap_d   = reload;
               state_d = GAP;
            end
            GAP, FULL: begin
               if (bus.tick) begin
                  // Move or expire every slot that was active. Expiry test
                  // x < speed keeps x from ever wrapping below zero.
                  for (int i = 0; i < 3; i++) begin
                     if (valid_q[i]) begin
                        if (x_q[i] < {7'b0, bus.speed})
                           valid_d[i] = 1'b0;
                        else
                           x_d[i] = x_q[i] - {7'b0, bus.speed};
                     end
                  end

                  if (state_q == GAP) begin
                     if (gap_q != 6'd0)
                        gap_d = gap_q - 6'd1;
                     else if (any_free)
                        do_spawn = 1'b1;
                     else
                        state_d = FULL;
                  end else begin
                     do_spawn = any_free;
                  end

                  if (do_spawn) begin
                     // Lowest-index free slot wins.
                     for (int i = 0; i < 3; i++) begin
                        if (free[i] && !placed) begin
                           placed     = 1'b1;
                           valid_d[i] = 1'b1;
                           x_d[i]     = X_START;
                           type_d[i]  = bus.rnd[1:0];
                        end
                     end
                     gap_d   = reload;
                     state_d = GAP;
                     spawn_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign bus.obs_valid   = valid_q;
   assign bus.obs_x       = x_q;
   assign bus.obs_type    = type_q;
   assign bus.spawn       = spawn_q;
   assign bus.dbg_state   = state_q;
   assign bus.dbg_gap_cnt = gap_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner
//   Directed bench for obstacle_spawner with hand-computed expectations.
module tb_obstacle_spawner;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_GAP  = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   logic clk;
   logic RESET;
   int   checks;
   int   errors;

   obstacle_spawner_if bus ();

   obstacle_spawner #(
      .X_START (10'd639),
      .MIN_GAP (24)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] slot_x(input int i);
      return bus.obs_x[i*10 +: 10];
   endfunction

   function automatic logic [1:0] slot_type(input int i);
      return bus.obs_type[i*2 +: 2];
   endfunction

   // One idle cycle, then one cycle with tick high; returns #1 after the
   // tick edge so the post-tick state and the spawn pulse are visible.
   task automatic do_tick();
      @(posedge clk); #1;
      bus.tick = 1'b1;
      @(posedge clk); #1;
      bus.tick = 1'b0;
   endtask

   // Reset, then release with run=1; returns with the DUT in GAP.
   task automatic start_game(input logic [4:0] r, input logic [2:0] spd);
      RESET      = 1'b0;
      bus.run    = 1'b1;
      bus.freeze = 1'b0;
      bus.tick   = 1'b0;
      bus.rnd    = r;
      bus.speed  = spd;
      repeat (2) @(posedge clk);
      #1;
      RESET = 1'b1;
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks     = 0;
      errors     = 0;
      RESET      = 1'b0;
      bus.tick   = 1'b0;
      bus.run    = 1'b1;
      bus.freeze = 1'b0;
      bus.speed  = 3'd2;
      bus.rnd    = 5'd6;

      // 1. Reset held two cycles with run=1 and tick pulsing.
      @(posedge clk); #1;
      bus.tick = 1'b1;
      @(posedge clk); #1;
      bus.tick = 1'b0;
      check_val("rst_valid", 32'(bus.obs_valid), 32'd0);
      check_val("rst_spawn", 32'(bus.spawn), 32'd0);
      check_val("rst_x", 32'(bus.obs_x), 32'd0);
      check_val("rst_type", 32'(bus.obs_type), 32'd0);
      check_val("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
      RESET = 1'b1;
      @(posedge clk); #1;
      check_val("entry_state", 32'(bus.dbg_state), 32'(S_GAP));
      check_val("entry_gap", 32'(bus.dbg_gap_cnt), 32'd30);

      // 2. Gap of 30: 30 silent ticks, spawn on tick 31.
      for (int t = 1; t <= 30; t++) begin
         do_tick();
         check_val("gap_silent", 32'(bus.spawn), 32'd0);
      end
      check_val("gap_zero", 32'(bus.dbg_gap_cnt), 32'd0);
      do_tick();
      check_val("g31_spawn", 32'(bus.spawn), 32'd1);
      check_val("g31_valid", 32'(bus.obs_valid), 32'b001);
      check_val("g31_x0", 32'(slot_x(0)), 32'd639);
      check_val("g31_type0", 32'(slot_type(0)), 32'd2);
      check_val("g31_reload", 32'(bus.dbg_gap_cnt), 32'd30);
      do_tick();
      check_val("g32_x0", 32'(slot_x(0)), 32'd637);
      check_val("g32_spawn", 32'(bus.spawn), 32'd0);
      check_val("g32_gap", 32'(bus.dbg_gap_cnt), 32'd29);

      // 5. Freeze for 10 ticks, then stop for one cycle.
      bus.freeze = 1'b1;
      for (int t = 0; t < 10; t++) do_tick();
      check_val("frz_gap", 32'(bus.dbg_gap_cnt), 32'd29);
      check_val("frz_x0", 32'(slot_x(0)), 32'd637);
      check_val("frz_valid", 32'(bus.obs_valid), 32'b001);
      check_val("frz_state", 32'(bus.dbg_state), 32'(S_GAP));
      check_val("frz_spawn", 32'(bus.spawn), 32'd0);
      bus.freeze = 1'b0;
      bus.run    = 1'b0;
      @(posedge clk); #1;
      bus.run = 1'b1;
      check_val("stop_valid", 32'(bus.obs_valid), 32'd0);
      check_val("stop_state", 32'(bus.dbg_state), 32'(S_IDLE));
      check_val("stop_gap", 32'(bus.dbg_gap_cnt), 32'd0);

      // 3. Expiry: gap 55 -> slot0 spawns on tick 56, speed 4.
      start_game(5'd31, 3'd4);
      check_val("exp_gap", 32'(bus.dbg_gap_cnt), 32'd55);
      for (int t = 1; t <= 56; t++) do_tick();
      check_val("exp_spawn", 32'(bus.spawn), 32'd1);
      check_val("exp_x0_start", 32'(slot_x(0)), 32'd639);
      check_val("exp_type0", 32'(slot_type(0)), 32'd3);
      for (int t = 57; t <= 215; t++) do_tick();
      check_val("exp_x0_3", 32'(slot_x(0)), 32'd3);
      check_val("exp_v0_alive", 32'(bus.obs_valid[0]), 32'd1);
      check_val("exp_x1", 32'(slot_x(1)), 32'd227);
      do_tick();
      check_val("exp_v0_clear", 32'(bus.obs_valid[0]), 32'd0);
      check_val("exp_x0_kept", 32'(slot_x(0)), 32'd3);
      check_val("exp_no_spawn", 32'(bus.spawn), 32'd0);

      // 4. Full / reuse: gap 24, speed 7.
      start_game(5'd0, 3'd7);
      for (int t = 1; t <= 100; t++) begin
         do_tick();
         check_val("full_spawn",
                   32'(bus.spawn),
                   (t == 25 || t == 50 || t == 75) ? 32'd1 : 32'd0);
      end
      check_val("t100_state", 32'(bus.dbg_state), 32'(S_FULL));
      check_val("t100_valid", 32'(bus.obs_valid), 32'b111);
      for (int t = 101; t <= 116; t++) do_tick();
      check_val("t116_x0", 32'(slot_x(0)), 32'd2);
      check_val("t116_valid", 32'(bus.obs_valid), 32'b111);
      do_tick();
      check_val("t117_valid", 32'(bus.obs_valid), 32'b110);
      check_val("t117_state", 32'(bus.dbg_state), 32'(S_FULL));
      check_val("t117_spawn", 32'(bus.spawn), 32'd0);
      do_tick();
      check_val("t118_spawn", 32'(bus.spawn), 32'd1);
      check_val("t118_valid", 32'(bus.obs_valid), 32'b111);
      check_val("t118_x0", 32'(slot_x(0)), 32'd639);
      check_val("t118_x1", 32'(slot_x(1)), 32'd163);
      check_val("t118_x2", 32'(slot_x(2)), 32'd338);
      check_val("t118_state", 32'(bus.dbg_state), 32'(S_GAP));
      check_val("t118_gap", 32'(bus.dbg_gap_cnt), 32'd24);

      // 6. Reset in FULL with two slots valid and tick high.
      start_game(5'd0, 3'd7);
      for (int t = 1; t <= 117; t++) do_tick();
      check_val("pre_rst_state", 32'(bus.dbg_state), 32'(S_FULL));
      check_val("pre_rst_valid", 32'(bus.obs_valid), 32'b110);
      RESET    = 1'b0;
      bus.tick = 1'b1;
      @(posedge clk); #1;
      bus.tick = 1'b0;
      check_val("mid_rst_valid", 32'(bus.obs_valid), 32'd0);
      check_val("mid_rst_x", 32'(bus.obs_x), 32'd0);
      check_val("mid_rst_type", 32'(bus.obs_type), 32'd0);
      check_val("mid_rst_spawn", 32'(bus.spawn), 32'd0);
      check_val("mid_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
      check_val("mid_rst_gap", 32'(bus.dbg_gap_cnt), 32'd0);
      RESET = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
